// File: rtl/queue_master.sv
// Command front-end for an external queue. It issues one enqueue or dequeue strobe per
// command, waits for the occupancy to change or for a timeout, and reports a result code.
module queue_master #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned GUARD   = 2
) (
  input  logic       clock_10KHZ,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic [3:0] q_len_in,
  input  logic [7:0] q_data_in,
  output logic       enqueue_out,
  output logic       dequeue_out,
  output logic [7:0] q_data_out,
  output logic [7:0] data_out,
  output logic       done_out,
  output logic [1:0] err_out,
  output logic [2:0] state_out
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned LEN_W = 4;
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD > 0) ? (GUARD - 1) : 0);
  localparam logic [LEN_W-1:0] LEN_FULL   = LEN_W'(8);
  localparam logic [LEN_W-1:0] LEN_EMPTY  = LEN_W'(0);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_FULL    = 2'b01;
  localparam logic [1:0] ERR_EMPTY   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3
  } state_t;

  state_t           r_state;
  logic             r_op;
  logic [LEN_W-1:0] r_len_snap;
  logic [CNT_W-1:0] r_cnt;
  logic             w_ack;

  assign w_ack     = (q_len_in != r_len_snap);
  assign state_out = r_state;

  // Whole controller: state, strobes, result code and captured data move together
  always_ff @(posedge clock_10KHZ) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_len_snap  <= '0;
      r_cnt       <= '0;
      cmd_ready   <= 1'b1;
      enqueue_out <= 1'b0;
      dequeue_out <= 1'b0;
      q_data_out  <= '0;
      data_out    <= '0;
      done_out    <= 1'b0;
      err_out     <= ERR_OK;
    end else begin
      done_out <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op       <= cmd_op;
            q_data_out <= cmd_data;
            r_len_snap <= q_len_in;
            r_cnt      <= '0;
            cmd_ready  <= 1'b0;
            if (!cmd_op && (q_len_in == LEN_FULL)) begin
              r_state  <= S_DONE;
              done_out <= 1'b1;
              err_out  <= ERR_FULL;
            end else if (cmd_op && (q_len_in == LEN_EMPTY)) begin
              r_state  <= S_DONE;
              done_out <= 1'b1;
              err_out  <= ERR_EMPTY;
            end else begin
              r_state     <= S_ISSUE;
              enqueue_out <= ~cmd_op;
              dequeue_out <= cmd_op;
            end
          end
        end

        S_ISSUE: begin
          // Any occupancy change acknowledges, and it takes priority over timeout
          if (w_ack) begin
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            r_cnt       <= '0;
            if (r_op) begin
              data_out <= q_data_in;
            end
            if (GUARD == 0) begin
              r_state  <= S_DONE;
              done_out <= 1'b1;
              err_out  <= ERR_OK;
            end else begin
              r_state <= S_SETTLE;
            end
          end else if (r_cnt == TO_LAST) begin
            enqueue_out <= 1'b0;
            dequeue_out <= 1'b0;
            r_state     <= S_DONE;
            done_out    <= 1'b1;
            err_out     <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_SETTLE: begin
          if (r_cnt == GUARD_LAST) begin
            r_state  <= S_DONE;
            done_out <= 1'b1;
            err_out  <= ERR_OK;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          cmd_ready <= 1'b1;
        end

        default: begin
          r_state     <= S_IDLE;
          cmd_ready   <= 1'b1;
          enqueue_out <= 1'b0;
          dequeue_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_master.sv
// Scoreboard bench for queue_master: a small queue model answers the strobes and
// expected result codes/data are queued at issue time and checked on done_out.
module tb_queue_master;

  localparam int unsigned TIMEOUT = 15;
  localparam int unsigned GUARD   = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready;
  logic [3:0] q_len_in = '0;
  logic [7:0] q_data_in = '0;
  logic       enqueue_out, dequeue_out;
  logic [7:0] q_data_out, data_out;
  logic       done_out;
  logic [1:0] err_out;
  logic [2:0] state_out;

  always #5 clk = ~clk;

  queue_master #(.TIMEOUT(TIMEOUT), .GUARD(GUARD)) dut (
    .clock_10KHZ(clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .q_len_in   (q_len_in),
    .q_data_in  (q_data_in),
    .enqueue_out(enqueue_out),
    .dequeue_out(dequeue_out),
    .q_data_out (q_data_out),
    .data_out   (data_out),
    .done_out   (done_out),
    .err_out    (err_out),
    .state_out  (state_out)
  );

  typedef struct {
    bit         op;
    logic [1:0] err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_fifo[$];
  logic [7:0] last_data = '0;
  logic [7:0] cur_data = '0;
  bit         cur_op = 1'b0;
  bit         active = 1'b0;
  bit         freeze = 1'b0;
  bit         acked = 1'b0;
  int         resp_delay = 1;
  int         scnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         hi_cnt = 0, lo_cnt = 0, last_hi = 0, last_lo = 0;
  int         done_cnt = 0, done_cyc = 0, acc_cyc = 0, done_base = 0;

  // One clock: sample outputs on the falling edge, score done_out, then let the model respond
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    n_checks++;
    if (enqueue_out && dequeue_out) begin
      n_fail++;
      $display("FAIL strobe_exclusive: enq=%0b deq=%0b, required not both high", enqueue_out, dequeue_out);
    end
    if (active && !cur_op && state_out != 3'd0) begin
      n_checks++;
      if (q_data_out !== cur_data) begin
        n_fail++;
        $display("FAIL q_data_out_hold: got %02h, required %02h", q_data_out, cur_data);
      end
    end
    if (done_out) begin
      done_cnt++;
      done_cyc = cyc;
      last_hi  = hi_cnt;
      last_lo  = lo_cnt;
      active   = 1'b0;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_done: done_out=1 with no command outstanding, required 0");
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (err_out !== e.err) begin
          n_fail++;
          $display("FAIL err_out: got %02b, required %02b", err_out, e.err);
        end
        n_checks++;
        if (data_out !== e.data) begin
          n_fail++;
          $display("FAIL data_out: got %02h, required %02h", data_out, e.data);
        end
      end
    end else if (enqueue_out || dequeue_out) begin
      hi_cnt++;
    end else if (hi_cnt > 0) begin
      lo_cnt++;
    end
    if (enqueue_out || dequeue_out) begin
      scnt++;
      if (!freeze && !acked && scnt >= resp_delay) begin
        acked = 1'b1;
        if (enqueue_out && m_fifo.size() < 8) m_fifo.push_back(q_data_out);
        else if (dequeue_out && m_fifo.size() > 0) q_data_in = m_fifo.pop_front();
      end
    end else begin
      scnt  = 0;
      acked = 1'b0;
    end
    q_len_in = 4'(m_fifo.size());
  endtask

  task automatic issue(input bit op, input logic [7:0] d, input bit hold);
    exp_t e;
    int w = 0;
    while (!cmd_ready && w < 50) begin
      cycle();
      w++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL ready_wait: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, w);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    e.op   = op;
    e.data = last_data;
    if (!op && m_fifo.size() == 8) e.err = 2'b01;
    else if (op && m_fifo.size() == 0) e.err = 2'b10;
    else if (freeze) e.err = 2'b11;
    else begin
      e.err = 2'b00;
      if (op) e.data = m_fifo[0];
    end
    last_data = e.data;
    exp_q.push_back(e);
    active    = 1'b1;
    cur_op    = op;
    cur_data  = d;
    hi_cnt    = 0;
    lo_cnt    = 0;
    acc_cyc   = cyc;
    done_base = done_cnt;
    cycle();
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int w = 0;
    while (done_cnt == done_base && w < budget) begin
      cycle();
      w++;
    end
    n_checks++;
    if (done_cnt == done_base) begin
      n_fail++;
      $display("FAIL done_wait: no done_out within %0d cycles, required one pulse", budget);
    end
  endtask

  task automatic load_fifo(input int n, input logic [7:0] first);
    m_fifo.delete();
    for (int i = 0; i < n; i++) m_fifo.push_back((i == 0) ? first : 8'(8'h40 + i));
    q_len_in = 4'(m_fifo.size());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle();
    cycle();
    n_checks++;
    if ({state_out, cmd_ready, enqueue_out, dequeue_out, done_out, err_out} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      n_fail++;
      $display("FAIL reset_ctrl: state=%0d rdy=%0b enq=%0b deq=%0b done=%0b err=%02b, required 0 1 0 0 0 00",
               state_out, cmd_ready, enqueue_out, dequeue_out, done_out, err_out);
    end
    n_checks++;
    if ({data_out, q_data_out} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: data_out=%02h q_data_out=%02h, required 00 00", data_out, q_data_out);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %0b, required 1", cmd_ready);
    end
  endtask

  task automatic test_push_ok();
    load_fifo(3, 8'h01);
    resp_delay = 2;
    issue(1'b0, 8'hA5, 1'b0);
    wait_done(40);
    n_checks++;
    if (last_hi != 2) begin
      n_fail++;
      $display("FAIL push_strobe_len: got %0d, required 2", last_hi);
    end
    n_checks++;
    if (last_lo != GUARD) begin
      n_fail++;
      $display("FAIL push_guard_len: got %0d, required %0d", last_lo, GUARD);
    end
    n_checks++;
    if (done_cyc - acc_cyc != 2 + GUARD + 1) begin
      n_fail++;
      $display("FAIL push_latency: got %0d, required %0d", done_cyc - acc_cyc, 2 + GUARD + 1);
    end
    n_checks++;
    if (q_data_out !== 8'hA5 || q_len_in !== 4'd4) begin
      n_fail++;
      $display("FAIL push_result: q_data_out=%02h len=%0d, required A5 4", q_data_out, q_len_in);
    end
  endtask

  task automatic test_pop_ok();
    load_fifo(5, 8'h3C);
    resp_delay = 1;
    issue(1'b1, 8'hFF, 1'b0);
    wait_done(40);
    n_checks++;
    if (data_out !== 8'h3C || q_len_in !== 4'd4) begin
      n_fail++;
      $display("FAIL pop_result: data_out=%02h len=%0d, required 3C 4", data_out, q_len_in);
    end
  endtask

  task automatic test_full_empty();
    load_fifo(8, 8'h99);
    issue(1'b0, 8'h12, 1'b0);
    wait_done(10);
    n_checks++;
    if (last_hi != 0 || done_cyc - acc_cyc != 1) begin
      n_fail++;
      $display("FAIL full_path: strobes=%0d latency=%0d, required 0 1", last_hi, done_cyc - acc_cyc);
    end
    load_fifo(0, 8'h00);
    issue(1'b1, 8'h00, 1'b0);
    wait_done(10);
    n_checks++;
    if (last_hi != 0 || done_cyc - acc_cyc != 1) begin
      n_fail++;
      $display("FAIL empty_path: strobes=%0d latency=%0d, required 0 1", last_hi, done_cyc - acc_cyc);
    end
  endtask

  task automatic test_timeout();
    load_fifo(2, 8'h77);
    freeze = 1'b1;
    issue(1'b1, 8'h00, 1'b0);
    wait_done(60);
    freeze = 1'b0;
    n_checks++;
    if (last_hi != TIMEOUT) begin
      n_fail++;
      $display("FAIL timeout_strobe_len: got %0d, required %0d", last_hi, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    load_fifo(1, 8'h55);
    resp_delay = 5;
    issue(1'b0, 8'h5A, 1'b0);
    base = done_cnt;
    exp_q.delete();
    active    = 1'b0;
    last_data = 8'h00;
    reset = 1'b1;
    cycle();
    n_checks++;
    if (enqueue_out !== 1'b0 || done_out !== 1'b0 || state_out !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mid: enq=%0b done=%0b state=%0d, required 0 0 0", enqueue_out, done_out, state_out);
    end
    reset = 1'b0;
    cycle();
    n_checks++;
    if (cmd_ready !== 1'b1 || done_cnt != base) begin
      n_fail++;
      $display("FAIL reset_mid_recover: rdy=%0b dones=%0d, required 1 %0d", cmd_ready, done_cnt, base);
    end
    resp_delay = 1;
    issue(1'b0, 8'h5A, 1'b0);
    wait_done(40);
  endtask

  task automatic test_back_to_back();
    load_fifo(0, 8'h00);
    resp_delay = 1;
    for (int i = 0; i < 9; i++) begin
      issue(1'b0, 8'(8'h10 + i), 1'b1);
      wait_done(40);
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (m_fifo.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d entries, required 8", m_fifo.size());
    end
    for (int i = 0; i < 8 && i < m_fifo.size(); i++) begin
      n_checks++;
      if (m_fifo[i] !== 8'(8'h10 + i)) begin
        n_fail++;
        $display("FAIL b2b_word%0d: got %02h, required %02h", i, m_fifo[i], 8'(8'h10 + i));
      end
    end
    cycle();
    cycle();
  endtask

  initial begin
    test_reset();
    test_push_ok();
    test_pop_ok();
    test_full_empty();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expect: %0d outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
